// File: rtl/m8c_issp_sequencer_pkg.sv
// Shared types and constants for the M8C ISSP vector sequencer.
package m8c_issp_pkg;

  localparam int VEC_W_DEFAULT = 22;

  localparam logic [7:0] CMD_NONE    = 8'd0;
  localparam logic [7:0] CMD_POR     = 8'd1;
  localparam logic [7:0] CMD_PWROFF  = 8'd2;
  localparam logic [7:0] CMD_SENDVEC = 8'd3;
  localparam logic [7:0] CMD_EXEC    = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_HALT
  } seq_state_e;

  localparam int ERR_OVF     = 0;
  localparam int ERR_ACK     = 1;
  localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/m8c_issp_sequencer_if.sv
// Command/handshake bundle between the sequencer (master) and the ISSP bit engine (slave).
interface m8c_issp_sequencer_if #(
  parameter int VEC_W = m8c_issp_pkg::VEC_W_DEFAULT
);
  logic [7:0]       eng_cmd;
  logic [VEC_W-1:0] eng_vec;
  logic [VEC_W-1:0] eng_mask;
  logic             eng_start;
  logic             eng_busy;
  logic [VEC_W-1:0] eng_rx;

  modport master (output eng_cmd, eng_vec, eng_mask, eng_start,
                  input  eng_busy, eng_rx);
  modport slave  (input  eng_cmd, eng_vec, eng_mask, eng_start,
                  output eng_busy, eng_rx);
endinterface

// File: rtl/m8c_issp_sequencer_vec_fifo.sv
// Synchronous show-ahead FIFO holding queued {vec, mask, exec} entries.
module m8c_issp_vec_fifo #(
  parameter int W          = 45,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  // A write into a full queue is accepted only when the head leaves in the same cycle.
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (do_wr && !do_rd)      count_d = count_q + (DEPTH_LOG2+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/m8c_issp_sequencer.sv
// Queues host ISSP vectors and issues them to the bit engine (SENDVEC, optional EXEC).
// Define M8C_SEQ_TIMEOUT_EN to add the engine busy-timeout watchdog (err[2]).
//
// state      | meaning
// IDLE       | waiting for a queued vector with no error pending
// ISSUE      | eng_start pulse, arm ack timer
// WAIT_ACK   | waiting for eng_busy to rise
// WAIT_DONE  | engine running; capture readback when busy falls
// HALT       | error stop; queue kept until err_clr
module m8c_issp_sequencer
  import m8c_issp_pkg::*;
#(
  parameter int VEC_W      = VEC_W_DEFAULT,
  parameter int DEPTH_LOG2 = 3,
  parameter int ACK_WAIT   = 15,
  parameter int TIMEOUT    = 65535
) (
  input  logic                osc,
  input  logic                rst_n,
  input  logic                push,
  input  logic [VEC_W-1:0]    push_vec,
  input  logic [VEC_W-1:0]    push_mask,
  input  logic                push_exec,
  output logic                q_full,
  output logic [DEPTH_LOG2:0] q_count,
  output logic [VEC_W-1:0]    rx_vec,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                idle,
  output logic [2:0]          err,
  input  logic                err_clr,
  m8c_issp_sequencer_if.master eng
);
  localparam int FW = 2*VEC_W + 1;
  localparam int AW = (ACK_WAIT < 1) ? 1 : $clog2(ACK_WAIT + 1);

  seq_state_e       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [VEC_W-1:0] vec_q, vec_d, mask_q, mask_d, rx_vec_q, rx_vec_d;
  logic             exec_q, exec_d, start_q, start_d, rx_valid_q, rx_valid_d;
  logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
  logic [2:0]       err_q, err_d, new_err;
  logic             pop, capture, fifo_empty;
  logic [FW-1:0]    head;

  m8c_issp_vec_fifo #(.W(FW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (osc),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({push_vec, push_mask, push_exec}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (q_count),
    .full    (q_full),
    .empty   (fifo_empty)
  );

`ifdef M8C_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    vec_d      = vec_q;
    mask_d     = mask_q;
    exec_d     = exec_q;
    start_d    = 1'b0;
    ack_cnt_d  = ack_cnt_q;
    pop        = 1'b0;
    capture    = 1'b0;
    new_err    = '0;
`ifdef M8C_SEQ_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    new_err[ERR_OVF] = push & q_full & ~pop;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && err_q == '0) begin
          pop = 1'b1;
          {vec_d, mask_d, exec_d} = head;
          cmd_d   = CMD_SENDVEC;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d   = 1'b1;
        ack_cnt_d = AW'(ACK_WAIT);
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (eng.eng_busy) begin
          state_d = ST_WAIT_DONE;
`ifdef M8C_SEQ_TIMEOUT_EN
          tmo_cnt_d = TW'(TIMEOUT - 1);
`endif
        end else if (ack_cnt_q == '0) begin
          new_err[ERR_ACK] = 1'b1;
          state_d = ST_HALT;
        end else begin
          ack_cnt_d = ack_cnt_q - AW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!eng.eng_busy) begin
          capture = (cmd_q == CMD_SENDVEC) && (mask_q != '0);
          if (cmd_q == CMD_SENDVEC && exec_q) begin
            cmd_d   = CMD_EXEC;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef M8C_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          new_err[ERR_TIMEOUT] = 1'b1;
          state_d = ST_HALT;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TW'(1);
        end
`endif
      end
      ST_HALT: begin
        if (err_clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_vec_d   = capture ? eng.eng_rx : rx_vec_q;
    rx_valid_d = (rx_valid_q & ~rx_ack) | capture;
    // A fresh error in the clearing cycle survives the clear.
    err_d      = (err_q & ~{3{err_clr}}) | new_err;
  end

  always_ff @(posedge osc) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NONE;
      vec_q      <= '0;
      mask_q     <= '0;
      exec_q     <= 1'b0;
      start_q    <= 1'b0;
      ack_cnt_q  <= '0;
      rx_vec_q   <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
`ifdef M8C_SEQ_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      vec_q      <= vec_d;
      mask_q     <= mask_d;
      exec_q     <= exec_d;
      start_q    <= start_d;
      ack_cnt_q  <= ack_cnt_d;
      rx_vec_q   <= rx_vec_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
`ifdef M8C_SEQ_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign eng.eng_cmd   = cmd_q;
  assign eng.eng_vec   = vec_q;
  assign eng.eng_mask  = mask_q;
  assign eng.eng_start = start_q;
  assign rx_vec        = rx_vec_q;
  assign rx_valid      = rx_valid_q;
  assign err           = err_q;
  assign idle          = fifo_empty & (state_q == ST_IDLE);
endmodule

// File: tb/tb_m8c_issp_sequencer.sv
// Directed bench for m8c_issp_sequencer with a simple bit-engine model.
module tb_m8c_issp_sequencer;
  import m8c_issp_pkg::*;

  localparam int VEC_W    = 22;
  localparam int DEPTH_L2 = 3;
  localparam int ACK_WAIT = 15;
  localparam int TIMEOUT  = 100;

  logic             osc = 1'b0;
  logic             rst_n, push, push_exec, rx_ack, err_clr;
  logic [VEC_W-1:0] push_vec, push_mask;
  logic             q_full, rx_valid, idle;
  logic [DEPTH_L2:0] q_count;
  logic [VEC_W-1:0] rx_vec;
  logic [2:0]       err;

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 osc = ~osc;

  m8c_issp_sequencer_if #(.VEC_W(VEC_W)) eng_if ();

  m8c_issp_sequencer #(
    .VEC_W(VEC_W), .DEPTH_LOG2(DEPTH_L2), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .osc(osc), .rst_n(rst_n), .push(push), .push_vec(push_vec), .push_mask(push_mask),
    .push_exec(push_exec), .q_full(q_full), .q_count(q_count), .rx_vec(rx_vec),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .idle(idle), .err(err), .err_clr(err_clr),
    .eng(eng_if)
  );

  // Engine model: mode 0 normal, 1 never acks, 2 busy held high.
  int   bfm_mode = 0;
  int   busy_cnt = 0;
  logic busy_r = 1'b0;
  assign eng_if.eng_busy = busy_r;
  assign eng_if.eng_rx   = 22'h2AAAAA;

  always @(posedge osc) begin
    if (eng_if.eng_start && bfm_mode != 1) begin
      busy_r   <= 1'b1;
      busy_cnt <= 50;
    end else if (busy_r && bfm_mode != 2) begin
      if (busy_cnt <= 1) busy_r <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  logic [7:0]       st_cmd[$];
  logic [VEC_W-1:0] st_vec[$];
  logic             st_rxv[$];
  int               n_start = 0;

  always @(posedge osc) begin
    if (eng_if.eng_start) begin
      st_cmd.push_back(eng_if.eng_cmd);
      st_vec.push_back(eng_if.eng_vec);
      st_rxv.push_back(rx_valid);
      n_start <= n_start + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge osc);
  endtask

  task automatic do_push(input logic [VEC_W-1:0] v, input logic [VEC_W-1:0] m, input logic x);
    push = 1'b1; push_vec = v; push_mask = m; push_exec = x;
    @(negedge osc);
    push = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge osc);
    err_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while (idle !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int i = 0;
    while (n_start < target && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, n_start, target);
  endtask

  task automatic wait_start_pulse(input int budget, input string tag);
    int i = 0;
    while (eng_if.eng_start !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, {31'd0, eng_if.eng_start}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    rst_n = 1'b0; push = 1'b0; push_vec = '0; push_mask = '0; push_exec = 1'b0;
    rx_ack = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("rst_idle",   {31'd0, idle}, 1);
    chk("rst_qcount", q_count, 0);
    chk("rst_qfull",  {31'd0, q_full}, 0);
    chk("rst_err",    err, 0);
    chk("rst_start",  {31'd0, eng_if.eng_start}, 0);
    chk("rst_cmd",    eng_if.eng_cmd, CMD_NONE);
    chk("rst_rxv",    {31'd0, rx_valid}, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: mask=0, no exec -> single SENDVEC, no capture, start 2 cycles after push
    b = n_start;
    do_push(22'h3FFFFF, 22'h0, 1'b0);
    chk("t1_qcount", q_count, 1);
    tick(1);
    chk("t1_start_early", {31'd0, eng_if.eng_start}, 0);
    chk("t1_qcount_pop", q_count, 0);
    tick(1);
    chk("t1_start", {31'd0, eng_if.eng_start}, 1);
    chk("t1_cmd", eng_if.eng_cmd, CMD_SENDVEC);
    chk("t1_vec", eng_if.eng_vec, 22'h3FFFFF);
    chk("t1_mask", eng_if.eng_mask, 0);
    tick(1);
    chk("t1_start_1cyc", {31'd0, eng_if.eng_start}, 0);
    wait_idle(100, "t1_idle");
    chk("t1_nstart", n_start - b, 1);
    chk("t1_rxv", {31'd0, rx_valid}, 0);

    // 2: mask nonzero with exec -> SENDVEC, capture, EXEC
    b = n_start;
    do_push(22'h012345, 22'h0000FF, 1'b1);
    wait_starts(b + 2, 200, "t2_starts");
    wait_idle(100, "t2_idle");
    chk("t2_cmd0", st_cmd[b], CMD_SENDVEC);
    chk("t2_cmd1", st_cmd[b+1], CMD_EXEC);
    chk("t2_vec1", st_vec[b+1], 22'h012345);
    chk("t2_rxv_at_send", {31'd0, st_rxv[b]}, 0);
    chk("t2_rxv_at_exec", {31'd0, st_rxv[b+1]}, 1);
    chk("t2_rxvec", rx_vec, 22'h2AAAAA);
    chk("t2_rxvalid", {31'd0, rx_valid}, 1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("t2_rxack", {31'd0, rx_valid}, 0);

    // 3: engine stalled, 10 back-to-back pushes -> 1 in flight, 8 queued, 1 dropped
    b = n_start;
    bfm_mode = 2;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; push_vec = 22'h100 + 22'(i); push_mask = '0; push_exec = 1'b0;
      tick(1);
    end
    push = 1'b0;
    chk("t3_qcount", q_count, 8);
    chk("t3_qfull", {31'd0, q_full}, 1);
    chk("t3_err_ovf", err, 3'b001);
    bfm_mode = 0;
    tick(60);
    chk("t3_blocked_starts", n_start - b, 1);
    chk("t3_blocked_qcount", q_count, 8);
    chk("t3_blocked_idle", {31'd0, idle}, 0);
    pulse_err_clr();
    chk("t3_errclr", err, 0);
    wait_starts(b + 9, 1000, "t3_starts");
    wait_idle(100, "t3_idle");
    for (int i = 0; i < 9; i++) chk($sformatf("t3_order%0d", i), st_vec[b+i], 22'h100 + 22'(i));
    chk("t3_nstart", n_start - b, 9);
    chk("t3_qfull_end", {31'd0, q_full}, 0);

    // 4: engine never acks -> ack error ACK_WAIT+1 cycles after start, HALT, err_clr resumes
    b = n_start;
    bfm_mode = 1;
    do_push(22'h0002A1, 22'h0, 1'b0);
    do_push(22'h0002B2, 22'h0, 1'b0);
    wait_start_pulse(20, "t4_start");
    tick(ACK_WAIT);
    chk("t4_err_before", err, 0);
    tick(1);
    chk("t4_err_ack", err, 3'b010);
    chk("t4_halt_idle", {31'd0, idle}, 0);
    chk("t4_halt_q", q_count, 1);
    tick(20);
    chk("t4_halt_nostart", n_start - b, 1);
    bfm_mode = 0;
    pulse_err_clr();
    chk("t4_errclr", err, 0);
    wait_starts(b + 2, 20, "t4_resume");
    chk("t4_vec2", st_vec[b+1], 22'h0002B2);
    wait_idle(100, "t4_idle");

    // 5: busy stuck high
    bfm_mode = 2;
    do_push(22'h000355, 22'h0, 1'b0);
    wait_start_pulse(20, "t5_start");
    tick(150);
`ifdef M8C_SEQ_TIMEOUT_EN
    chk("t5_err_tmo", err, 3'b100);
    chk("t5_idle", {31'd0, idle}, 0);
    bfm_mode = 0;
    tick(2);
    pulse_err_clr();
`else
    chk("t5_err_none", err, 0);
    chk("t5_idle", {31'd0, idle}, 0);
    bfm_mode = 0;
`endif
    wait_idle(100, "t5_idle_end");
    chk("t5_err_end", err, 0);

    // 6: reset during WAIT_DONE drops everything
    b = n_start;
    do_push(22'h0003C3, 22'h0000F0, 1'b0);
    do_push(22'h0003C4, 22'h0, 1'b0);
    do_push(22'h0003C5, 22'h0, 1'b0);
    wait_starts(b + 1, 20, "t6_start");
    tick(5);
    chk("t6_q_before", q_count, 2);
    rst_n = 1'b0;
    tick(1);
    chk("t6_qcount", q_count, 0);
    chk("t6_idle", {31'd0, idle}, 1);
    chk("t6_start", {31'd0, eng_if.eng_start}, 0);
    chk("t6_cmd", eng_if.eng_cmd, CMD_NONE);
    chk("t6_vec", eng_if.eng_vec, 0);
    chk("t6_mask", eng_if.eng_mask, 0);
    chk("t6_rxvec", rx_vec, 0);
    chk("t6_rxv", {31'd0, rx_valid}, 0);
    chk("t6_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(150);
    chk("t6_nostart", n_start - b, 1);
    chk("t6_idle_after", {31'd0, idle}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
